// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the counter checker:
//   - MATCH_W : width of the consecutive-match counter. It is wide enough for
//               any LOCK_N in the supported range 1..15.
//   - state_e : checker FSM states (IDLE, ACQUIRE, LOCKED). Explicit encodings
//               keep the debug port value stable across tools.
//   - wrap_inc: the next value of a free-running incrementing counter.
// ---------------------------------------------------------------------------
package counter_pkg;

   localparam int MATCH_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

   // Plain addition truncated to the operand width gives modulo 2^W, so the
   // prediction after the all-ones value is zero. This makes the wrap a match.
   function automatic logic [31:0] wrap_inc(input logic [31:0] val,
                                            input int          width);
      logic [31:0] mask;
      mask     = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      wrap_inc = (val + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Counts up by one for each cycle with inc=1. The count stops at all-ones and
// stays there. clr returns the count to zero and takes priority over inc.
//
// Ports:
//   clk   : input, rising-edge clock
//   rst_n : input, asynchronous active-low reset; q goes to 0
//   clr   : input, synchronous clear; q goes to 0
//   inc   : input, increment request for this cycle
//   q     : output [W-1:0], registered count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic at_max;

   assign at_max = (q == {W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !at_max) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/counter_checker.sv
// ---------------------------------------------------------------------------
// counter_checker
//
// Watches samples from an incrementing counter and checks that the counter
// really increments. The checker first needs LOCK_N consecutive correct
// increments to lock. After it locks, any sample that breaks the sequence is
// counted as an error. The checker then drops back to ACQUIRE to resynchronise.
// Each valid sample also reloads the prediction with in_val+1, so a single bad
// sample produces one error and does not produce a cascade of errors.
//
// Input handshake: in_valid=1 means in_val carries a sample this cycle. There
// is no back-pressure. A sample offered with clear=1 is discarded.
//
// Parameters:
//   SIZE   : width of the monitored counter value
//   LOCK_N : consecutive matches needed to lock (1..15)
//   ERR_W  : width of the saturating error counter
//
// Ports:
//   clk        : input, rising-edge clock
//   rst_n      : input, asynchronous active-low reset
//   in_valid   : input, in_val holds a sample
//   in_val     : input [SIZE-1:0], observed counter value
//   clear      : input, synchronous restart of checking and statistics
//   locked     : output, FSM is in LOCKED
//   mismatch   : output, one-cycle pulse for each counted error
//   err_sticky : output, at least one error since reset or clear
//   err_count  : output [ERR_W-1:0], saturating error count
//   expected   : output [SIZE-1:0], predicted next in_val
//   dbg_state  : output, current FSM state for observation
//
// All outputs except dbg_state come from flops that are loaded with next-state
// values. They therefore change in the cycle after the sample that decides them.
// ---------------------------------------------------------------------------
module counter_checker
   import counter_pkg::*;
#(
   parameter int SIZE   = 16,
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [SIZE-1:0]  in_val,
   input  logic             clear,
   output logic             locked,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic [SIZE-1:0]  expected,
   output state_e           dbg_state
);

   localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_N);

   state_e             state_q;
   state_e             state_d;
   logic [MATCH_W-1:0] match_q;
   logic [MATCH_W-1:0] match_d;
   logic [MATCH_W-1:0] match_inc;
   logic               take_sample;
   logic               hit;
   logic               err_event;
   logic [SIZE-1:0]    next_pred;

   // clear has priority over in_valid, so a sample offered together with
   // clear is never seen by the FSM.
   assign take_sample = in_valid && !clear;
   assign hit         = (in_val == expected);
   assign match_inc   = match_q + MATCH_W'(1);
   assign next_pred   = SIZE'(wrap_inc(32'(in_val), SIZE));

   // -------------------------------------------------------------------------
   // FSM next-state logic and match counting
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      err_event = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         match_d = '0;
      end else if (in_valid) begin
         case (state_q)
            ST_IDLE: begin
               // The first sample only seeds the prediction and cannot match.
               state_d = ST_ACQUIRE;
               match_d = '0;
            end
            ST_ACQUIRE: begin
               if (hit) begin
                  match_d = match_inc;
                  if (match_inc >= LOCK_TGT) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  // A broken sequence while acquiring restarts the run.
                  // It is not counted as an error.
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!hit) begin
                  state_d   = ST_ACQUIRE;
                  match_d   = '0;
                  err_event = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               match_d = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         match_q    <= '0;
         locked     <= 1'b0;
         mismatch   <= 1'b0;
         err_sticky <= 1'b0;
         expected   <= '0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         locked   <= (state_d == ST_LOCKED);
         mismatch <= err_event;
         if (clear) begin
            err_sticky <= 1'b0;
         end else if (err_event) begin
            err_sticky <= 1'b1;
         end
         // The prediction resynchronises on every accepted sample.
         // clear leaves the prediction unchanged.
         if (take_sample) begin
            expected <= next_pred;
         end
      end
   end

   assign dbg_state = state_q;

   // -------------------------------------------------------------------------
   // Saturating error counter
   // -------------------------------------------------------------------------
   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (err_event),
      .q     (err_count)
   );

endmodule

// File: tb/tb_counter_checker.sv
// ---------------------------------------------------------------------------
// tb_counter_checker
//
// Directed bench for counter_checker with SIZE=4, LOCK_N=2 and ERR_W=2.
// A reference model tracks the sample history:
//   - whether a seed sample has been seen,
//   - the length of the current run of correct increments,
//   - whether the run has reached lock,
//   - the total number of errors.
// A compare process checks every DUT output against this model on each
// falling clock edge. Hand-computed literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_counter_checker;
   import counter_pkg::*;

   localparam int SIZE    = 4;
   localparam int LOCK_N  = 2;
   localparam int ERR_W   = 2;
   localparam int MOD     = 1 << SIZE;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   // ---------------- clock / reset ----------------
   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic             in_valid = 1'b0;
   logic [SIZE-1:0]  in_val   = '0;
   logic             clear    = 1'b0;
   logic             locked;
   logic             mismatch;
   logic             err_sticky;
   logic [ERR_W-1:0] err_count;
   logic [SIZE-1:0]  expected;
   state_e           dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_checker #(
      .SIZE   (SIZE),
      .LOCK_N (LOCK_N),
      .ERR_W  (ERR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_val     (in_val),
      .clear      (clear),
      .locked     (locked),
      .mismatch   (mismatch),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .expected   (expected),
      .dbg_state  (dbg_state)
   );

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_seen   = 1'b0;
   bit m_locked = 1'b0;
   bit m_mis    = 1'b0;
   int m_run    = 0;
   int m_errs   = 0;
   int m_exp    = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_seen = 1'b0; m_locked = 1'b0; m_mis = 1'b0;
         m_run = 0; m_errs = 0; m_exp = 0;
      end else begin
         m_mis = 1'b0;
         if (clear) begin
            m_seen = 1'b0; m_locked = 1'b0; m_run = 0; m_errs = 0;
         end else if (in_valid) begin
            if (!m_seen) begin
               m_seen = 1'b1; m_run = 0; m_locked = 1'b0;
            end else if (int'(in_val) == m_exp) begin
               if (!m_locked) begin
                  m_run++;
                  if (m_run >= LOCK_N) m_locked = 1'b1;
               end
            end else if (m_locked) begin
               m_mis = 1'b1; m_errs++; m_locked = 1'b0; m_run = 0;
            end else begin
               m_run = 0;
            end
            m_exp = (int'(in_val) + 1) % MOD;
         end
      end
   end

   // Compare process: outputs are meaningful on every cycle.
   always @(negedge clk) begin
      chk("locked",     32'(locked),     32'(m_locked));
      chk("mismatch",   32'(mismatch),   32'(m_mis));
      chk("err_count",  32'(err_count),  32'((m_errs > ERR_MAX) ? ERR_MAX : m_errs));
      chk("err_sticky", 32'(err_sticky), 32'(m_errs > 0));
      chk("expected",   32'(expected),   32'(m_exp));
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int v);
      in_valid = 1'b1;
      in_val   = SIZE'(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_clear(input int v);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_val   = SIZE'(v);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int v;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_locked",   32'(locked),    0);
      chk("rst_count",    32'(err_count), 0);
      chk("rst_expected", 32'(expected),  0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      // Lock on 3,4,5
      send(3);
      send(4);
      chk("acq_not_locked", 32'(locked), 0);
      send(5);
      chk("lock_locked",   32'(locked),   1);
      chk("lock_mismatch", 32'(mismatch), 0);
      chk("lock_expected", 32'(expected), 6);

      // Run up to the wrap while locked
      for (int i = 6; i <= 13; i++) send(i);
      send(14); send(15);
      send(0);
      chk("wrap_mismatch", 32'(mismatch), 0);
      send(1);
      chk("wrap_locked",   32'(locked),   1);
      chk("wrap_expected", 32'(expected), 2);
      idle(2);
      chk("hold_locked", 32'(locked), 1);

      // Error while locked with expected 7
      for (int i = 2; i <= 6; i++) send(i);
      chk("pre_err_expected", 32'(expected), 7);
      send(9);
      chk("err_mismatch", 32'(mismatch),   1);
      chk("err_count1",   32'(err_count),  1);
      chk("err_sticky",   32'(err_sticky), 1);
      chk("err_unlocked", 32'(locked),     0);
      chk("err_expected", 32'(expected),   10);
      idle(1);
      chk("pulse_end", 32'(mismatch), 0);
      send(10); send(11);
      chk("relock", 32'(locked), 1);

      // Four more lock/mismatch cycles, five errors in total
      v = 11;
      repeat (4) begin
         v = (v + 3) % MOD; send(v);
         chk("loop_mismatch", 32'(mismatch), 1);
         v = (v + 1) % MOD; send(v);
         v = (v + 1) % MOD; send(v);
      end
      chk("sat_count",  32'(err_count),  3);
      chk("sat_sticky", 32'(err_sticky), 1);
      chk("sat_locked", 32'(locked),     1);
      send(0);
      chk("pre_clear_expected", 32'(expected), 1);

      // clear together with a sample: clear wins
      send_clear(5);
      chk("clr_state",    32'(dbg_state),  32'(ST_IDLE));
      chk("clr_locked",   32'(locked),     0);
      chk("clr_count",    32'(err_count),  0);
      chk("clr_sticky",   32'(err_sticky), 0);
      chk("clr_expected", 32'(expected),   1);

      // The next sample is a seed; then a break during ACQUIRE is not an error
      send(8);
      chk("seed_expected", 32'(expected), 9);
      chk("seed_mismatch", 32'(mismatch), 0);
      send(9);
      send(3);
      chk("acq_break_mismatch", 32'(mismatch),  0);
      chk("acq_break_count",    32'(err_count), 0);
      chk("acq_break_expected", 32'(expected),  4);

      // Asynchronous reset pulse between edges while in ACQUIRE
      #1 rst_n = 1'b0;
      #1;
      chk("arst_state",    32'(dbg_state),  32'(ST_IDLE));
      chk("arst_locked",   32'(locked),     0);
      chk("arst_mismatch", 32'(mismatch),   0);
      chk("arst_sticky",   32'(err_sticky), 0);
      chk("arst_count",    32'(err_count),  0);
      chk("arst_expected", 32'(expected),   0);
      #1 rst_n = 1'b1;

      // History is gone: 7 is a seed sample
      send(7);
      chk("post_rst_expected", 32'(expected), 8);
      chk("post_rst_mismatch", 32'(mismatch), 0);
      send(8); send(9);
      chk("post_rst_locked", 32'(locked), 1);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
